scan_ctl: RTL and testbench
===========================

# scan_ctl

Scan-chain controller: the driving end of a chain of scan flip-flops (d/ti/te/cp cells clocked by sys_clk with cp as clock-enable). It loads a parallel test pattern serially into the chain, pulses one functional capture cycle, then shifts the captured response back out serially and presents it as a parallel word. It sits between the debug/test register file and the netlist-derived scan chains, one instance per chain.

## Interface

- CHAIN_LEN, 32, number of scan cells in the chain (N); legal range 2..256; counter width is $clog2(CHAIN_LEN+1)

- sys_clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one load/capture/unload sequence; sampled only in IDLE or DONE
- pattern_in  in  CHAIN_LEN  stimulus; bit i lands in chain cell i (cell 0 nearest ti)
- expected  in  CHAIN_LEN  expected response (used only with SCAN_CMP_EN)
- so  in  1  scan-out, q of chain cell N-1
- te  out  1  test-enable to all chain cells (1 = shift, 0 = functional capture)
- ti  out  1  serial scan-in to cell 0
- cp  out  1  clock-enable strobe to all chain cells
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, result valid
- result  out  CHAIN_LEN  captured response; bit i = cell i after capture
- mismatch  out  1  result != expected, valid with done and held

## Operation

- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: te=0, cp=0, ti=0, busy=0. start=1 → latch pattern_in into shift register, clear bit counter, → SHIFT_IN.
- SHIFT_IN (N cycles): te=1, cp=1, ti = shift register MSB (pattern bit N-1 first, bit 0 last); shift register shifts left once per cycle. After N cycles → CAPTURE.
- CAPTURE (1 cycle): te=0, cp=1, ti=0. Chain loads its functional d inputs. → SHIFT_OUT.
- SHIFT_OUT (N cycles): te=1, cp=1, ti=0. Each cycle result <= {result[N-2:0], so}. After N cycles → DONE.
- DONE (1 cycle): te=0, cp=0, done=1, busy=0. start=1 → behaves as IDLE start (back-to-back); else → IDLE.
- start in SHIFT_IN/CAPTURE/SHIFT_OUT ignored; pattern_in changes after acceptance ignored.
- result holds from DONE until the next SHIFT_OUT begins overwriting it; cleared only by reset.

## Timing

- te, ti, cp, busy, done, mismatch are registered (Moore, from state/datapath flops); no combinational path from any input to any output.
- start sampled at edge E0 → SHIFT_IN occupies cycles 1..N, CAPTURE cycle N+1, SHIFT_OUT cycles N+2..2N+1, done=1 in cycle 2N+2. busy=1 in cycles 1..2N+1.
- so sampled on the same edge at which cp=1 shifts the chain (pre-shift value).
- Counter counts 0..N-1 in each shift state, reset to 0 on each state entry; no wrap beyond N-1.
- Reset (any state, any cycle): → IDLE; te=0, ti=0, cp=0, busy=0, done=0, mismatch=0, result=0, shift register=0. No done pulse for the aborted sequence. Chain contents are not restored.
- reset and start high in same cycle: reset wins.

## Configuration

- SCAN_CMP_EN defined: comparator computes result != expected at the SHIFT_OUT→DONE transition (using final result word); mismatch registered, asserted with done, held until next accepted start (cleared then) or reset.
- SCAN_CMP_EN undefined: no comparator logic; expected unused; mismatch tied 0.

## Test plan

- CHAIN_LEN=8, chain modelled as 8 scan cells with d = ~q; pattern_in=0xA5, start pulse at E0 → te/cp sequence as specified, ti stream 1,0,1,0,0,1,0,1, done in cycle 18 only, result=0x5A.
- Same, SCAN_CMP_EN defined, expected=0x5A → mismatch=0 at done; expected=0x5B → mismatch=1 at done and held until next start.
- start re-asserted in cycles 3 and 10 → ignored; exactly one done pulse at cycle 18, result=0x5A.
- start held high through DONE → second sequence begins cycle 19, second done in cycle 36; busy low only in cycle 18.
- reset at cycle 12 (SHIFT_OUT) → next cycle te=0, cp=0, busy=0, result=0, no done; new start afterwards completes normally.
- Undefined SCAN_CMP_EN, expected=0xFF → mismatch stays 0 throughout.

Source files
------------

// File: rtl/scan_ctl.sv
// scan_ctl: serial load / capture / unload controller for one scan chain; define SCAN_CMP_EN to add the response comparator
module scan_ctl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 so,
  output logic                 te,
  output logic                 ti,
  output logic                 cp,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 mismatch
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CHAIN_LEN-1:0] sr;
  logic last, accept, shifting;
  assign last = cnt == CW'(CHAIN_LEN - 1);
  assign accept = (state == IDLE || state == DONE) && start;
  assign shifting = state == SHIFT_IN || state == SHIFT_OUT;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = SHIFT_IN;
    else if (state == DONE) state_nxt = IDLE;
    else if (state == CAPTURE) state_nxt = SHIFT_OUT;
    else if (shifting && last) state_nxt = state == SHIFT_IN ? CAPTURE : DONE;
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (shifting && state_nxt == state) ? cnt + CW'(1) : '0;
      sr    <= accept ? pattern_in : state == SHIFT_IN ? sr << 1 : sr;
      if (state == SHIFT_OUT) result <= {result[CHAIN_LEN-2:0], so};
    end
  end
  // all outputs decode the state and shift-register flops only
  assign te   = shifting;
  assign cp   = shifting || state == CAPTURE;
  assign busy = cp;
  assign ti   = state == SHIFT_IN && sr[CHAIN_LEN-1];
  assign done = state == DONE;
`ifdef SCAN_CMP_EN
  always_ff @(posedge sys_clk) begin
    if (reset || accept) mismatch <= 1'b0;
    else if (state == SHIFT_OUT && last) mismatch <= {result[CHAIN_LEN-2:0], so} != expected;
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_scan_ctl.sv
// tb_scan_ctl: randomized and directed checks of scan_ctl against a timeline model of one sequence, with an inverting scan chain
module tb_scan_ctl;
  localparam int N = 8;
`ifdef SCAN_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  logic sys_clk = 1'b0, reset = 1'b1, start = 1'b0, so;
  logic [N-1:0] pattern_in = '0, expected = '0, result;
  logic te, ti, cp, busy, done, mismatch;
  logic [N-1:0] chain = '0;
  int vectors = 0, miscompares = 0;
  int t = 0;
  logic [N-1:0] m_pat = '0, m_res = '0;
  logic m_mm = 1'b0;
  bit chk = 1'b0;

  scan_ctl #(.CHAIN_LEN(N)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .pattern_in(pattern_in),
    .expected(expected), .so(so), .te(te), .ti(ti), .cp(cp), .busy(busy),
    .done(done), .result(result), .mismatch(mismatch)
  );

  always #5 sys_clk = ~sys_clk;

  // scan chain whose functional input is the inverse of each cell
  assign so = chain[N-1];
  always @(posedge sys_clk) if (cp) chain <= te ? {chain[N-2:0], ti} : ~chain;

  // t = cycles since the accepting edge; 0 when idle
  initial forever begin
    @(posedge sys_clk);
    if (reset) begin
      t = 0; m_res = '0; m_mm = 1'b0; chk = 1'b1;
    end else if ((t == 0 || t == 2*N+2) && start) begin
      t = 1; m_pat = pattern_in; m_mm = 1'b0;
    end else if (t == 2*N+2) t = 0;
    else if (t > 0) t = t + 1;
    if (t == 2*N+2) begin
      m_res = ~m_pat;
      m_mm = CMP && ((~m_pat) != expected);
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk) begin
      logic e_te, e_cp, e_ti, e_done, rchk;
      e_te   = (t >= 1 && t <= N) || (t >= N+2 && t <= 2*N+1);
      e_cp   = t >= 1 && t <= 2*N+1;
      e_ti   = (t >= 1 && t <= N) ? m_pat[N-t] : 1'b0;
      e_done = t == 2*N+2;
      rchk   = t <= N+2 || t == 2*N+2;
      vectors++;
      if ({te, cp, ti, busy, done, mismatch} !== {e_te, e_cp, e_ti, e_cp, e_done, m_mm} ||
          (rchk && result !== m_res)) begin
        miscompares++;
        $display("FAIL cycle_model t=%0d: te cp ti busy done mm = %b%b%b%b%b%b required %b%b%b%b%b%b, result=%h required %h (checked=%0d)",
                 t, te, cp, ti, busy, done, mismatch, e_te, e_cp, e_ti, e_cp, e_done, m_mm, result, m_res, rchk);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] ex, input bit poke,
                         output logic [N-1:0] stream, output int nd, output int dcyc,
                         output logic [N-1:0] res, output logic mm);
    pattern_in = pat; expected = ex; start = 1'b1;
    tick();
    start = 1'b0; pattern_in = ~pat;
    stream = '0; nd = 0; dcyc = 0; res = '0; mm = 1'b0;
    for (int k = 1; k <= 2*N+2; k++) begin
      start = poke && (k == 3 || k == 10);
      @(negedge sys_clk);
      if (k <= N) stream = {stream[N-2:0], ti};
      if (done) begin nd++; dcyc = k; end
      if (k == 2*N+2) begin res = result; mm = mismatch; end
      if (k < 2*N+2) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [N-1:0] stream, res;
    logic mm;
    int nd, dcyc, low, lowsum;
    tick(); tick();
    reset = 1'b0;
    tick();
    run_seq(8'hA5, 8'h5A, 1'b0, stream, nd, dcyc, res, mm);
    check("ti_stream", stream, 8'hA5);
    check("done_count", nd, 1);
    check("done_cycle", dcyc, 18);
    check("result_a5", res, 8'h5A);
    check("mismatch_equal", mm, 1'b0);
    tick();
    run_seq(8'hA5, 8'h5B, 1'b1, stream, nd, dcyc, res, mm);
    check("poked_done_count", nd, 1);
    check("poked_done_cycle", dcyc, 18);
    check("poked_result", res, 8'h5A);
    check("mismatch_diff", mm, CMP);
    tick(); tick(); tick();
    check("mismatch_held", mismatch, CMP);
    tick();
    run_seq(8'hA5, 8'hFF, 1'b0, stream, nd, dcyc, res, mm);
    check("mismatch_ff", mm, CMP);
    tick();
    pattern_in = 8'hA5; start = 1'b1;
    tick();
    low = 0; lowsum = 0; nd = 0; dcyc = 0;
    for (int k = 1; k <= 4*N+4; k++) begin
      @(negedge sys_clk);
      if (!busy) begin low++; lowsum += k; end
      if (done) begin nd++; dcyc = k; end
      if (k < 4*N+4) tick();
    end
    start = 1'b0;
    check("b2b_busy_low_count", low, 2);
    check("b2b_busy_low_cycles", lowsum, 18 + 36);
    check("b2b_done_count", nd, 2);
    check("b2b_last_done", dcyc, 36);
    repeat (2*N+6) tick();
    pattern_in = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sys_clk);
    check("abort_te_cp_busy", {te, cp, busy, done}, 4'b0000);
    check("abort_result", result, 0);
    nd = 0;
    for (int k = 0; k < 2*N+6; k++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 3) == 0;
      pattern_in = N'($urandom);
      expected = $urandom_range(0, 1) ? ~m_pat : N'($urandom);
      reset = $urandom_range(0, 299) == 0;
      tick();
    end
    reset = 1'b0; start = 1'b0;
    repeat (2*N+6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
